// File: rtl/gin_bus_buffered.sv
// ----------------------------------------------------------------------------
// gin_bus_buffered
//
// Global-input-network bus with a buffered output stage per controller. A scan
// chain loads one tag ID into each controller. A source word presented with a
// destination tag is pushed into the FIFO of every controller whose ID matches.
// Each FIFO then drains to its own target through a separate enable/ready
// handshake.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where valid and
// ready are both 1. Valid may not depend on ready. On the bus, valid is
// i_bus_enable and ready is o_bus_ready. On each target, valid is
// o_target_enable[i] and ready is i_target_ready[i].
//
// Optional feature: define GIN_BROADCAST_EN to make the all-ones tag match
// every controller.
//
// Ports
//   i_clk                clock; all state updates happen on the rising edge
//   i_rst                synchronous active-high reset
//   i_program            scan-chain shift enable; blocks bus acceptance
//   i_scan_tag_in        scan data shifted into controller 0
//   o_scan_tag_next_bus  ID of the last controller, for chaining to another bus
//   i_bus_enable         source valid
//   o_bus_ready          bus can accept a word this cycle
//   i_tag                destination tag of the presented word
//   i_data_source        presented word
//   i_target_ready       per-target ready
//   o_target_enable      per-target valid (FIFO i is non-empty)
//   o_output_value       FIFO heads; controller i is in slice i (0 when empty)
//   o_bus_idle           all FIFOs are empty and i_program is low
// ----------------------------------------------------------------------------
module gin_bus_buffered #(
   parameter int BITWIDTH        = 16,
   parameter int TAG_LENGTH      = 4,
   parameter int NUM_CONTROLLERS = 10,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_program,
   input  logic [TAG_LENGTH-1:0]               i_scan_tag_in,
   output logic [TAG_LENGTH-1:0]               o_scan_tag_next_bus,
   input  logic                                i_bus_enable,
   output logic                                o_bus_ready,
   input  logic [TAG_LENGTH-1:0]               i_tag,
   input  logic [BITWIDTH-1:0]                 i_data_source,
   input  logic [NUM_CONTROLLERS-1:0]          i_target_ready,
   output logic [NUM_CONTROLLERS-1:0]          o_target_enable,
   output logic [BITWIDTH*NUM_CONTROLLERS-1:0] o_output_value,
   output logic                                o_bus_idle
);

   localparam int          AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   logic [TAG_LENGTH-1:0]      r_id [NUM_CONTROLLERS];
   logic [NUM_CONTROLLERS-1:0] w_match;
   logic [NUM_CONTROLLERS-1:0] w_full;
   logic [NUM_CONTROLLERS-1:0] w_empty;
   logic [NUM_CONTROLLERS-1:0] w_push;
   logic [NUM_CONTROLLERS-1:0] w_pop;
   logic                       w_bcast;
   logic                       w_accept;

`ifdef GIN_BROADCAST_EN
   assign w_bcast = &i_tag;
`else
   assign w_bcast = 1'b0;
`endif

   // Ready depends only on the tag, i_program and the registered full flags.
   // It never depends on target ready, so a pop in the same cycle cannot make
   // room in a full FIFO.
   assign o_bus_ready         = !i_program && (&(~w_match | ~w_full));
   assign w_accept            = i_bus_enable && o_bus_ready;
   assign o_bus_idle          = (&w_empty) && !i_program;
   assign o_scan_tag_next_bus = r_id[NUM_CONTROLLERS-1];

   // Scan chain: controller 0 takes the scan input and every later controller
   // takes its predecessor's ID.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_CONTROLLERS; i++) r_id[i] <= '0;
      end else if (i_program) begin
         r_id[0] <= i_scan_tag_in;
         for (int i = 1; i < NUM_CONTROLLERS; i++) r_id[i] <= r_id[i-1];
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CONTROLLERS; g++) begin : g_ctrl
         logic [BITWIDTH-1:0] r_mem [FIFO_DEPTH];
         logic [AW-1:0]       r_rd_ptr;
         logic [AW-1:0]       r_wr_ptr;
         logic [AW:0]         r_count;

         assign w_match[g] = w_bcast || (r_id[g] == i_tag);
         assign w_full[g]  = (r_count == FULL_COUNT);
         assign w_empty[g] = (r_count == '0);
         assign w_push[g]  = w_accept && w_match[g];
         // A pop needs a word already in the FIFO, so a word pushed into an
         // empty FIFO becomes visible on the next cycle.
         assign w_pop[g]   = !w_empty[g] && i_target_ready[g];

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_rd_ptr <= '0;
               r_wr_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (w_push[g]) r_wr_ptr <= r_wr_ptr + AW'(1);
               if (w_pop[g])  r_rd_ptr <= r_rd_ptr + AW'(1);
               case ({w_push[g], w_pop[g]})
                  2'b10:   r_count <= r_count + (AW+1)'(1);
                  2'b01:   r_count <= r_count - (AW+1)'(1);
                  default: r_count <= r_count;
               endcase
            end
         end

         // Storage needs no reset because the output slice is forced to 0
         // whenever the FIFO is empty.
         always_ff @(posedge i_clk) begin
            if (w_push[g]) r_mem[r_wr_ptr] <= i_data_source;
         end

         assign o_target_enable[g] = !w_empty[g];
         assign o_output_value[g*BITWIDTH +: BITWIDTH] =
            w_empty[g] ? '0 : r_mem[r_rd_ptr];
      end
   endgenerate

endmodule
